// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the MEM stage: writeback select encodings,
// MEM-stage FSM states and datapath widths.
package mem_stage_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int MTR_W      = 2;

    typedef enum logic [MTR_W-1:0] {
        MTR_ALU = 2'b00,
        MTR_MEM = 2'b01,
        MTR_PC4 = 2'b10
    } mem_to_reg_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register bank; a bubble clears the valid, write enable
// and payload while the error pulses still pass through.
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bubble,
    input  logic [MTR_W-1:0]      mem_to_reg,
    input  logic                  reg_write,
    input  logic [DATA_W-1:0]     read_data,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [REG_ADDR_W-1:0] write_register,
    input  logic                  align_err,
    input  logic                  bus_err,
    output logic [MTR_W-1:0]      mem_to_reg_o,
    output logic                  reg_write_o,
    output logic                  wb_valid_o,
    output logic [DATA_W-1:0]     read_data_o,
    output logic [DATA_W-1:0]     alu_result_o,
    output logic [REG_ADDR_W-1:0] write_register_o,
    output logic                  align_err_o,
    output logic                  bus_err_o
);

    // MEM -> WB boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_to_reg_o     <= '0;
            reg_write_o      <= 1'b0;
            wb_valid_o       <= 1'b0;
            read_data_o      <= '0;
            alu_result_o     <= '0;
            write_register_o <= '0;
            align_err_o      <= 1'b0;
            bus_err_o        <= 1'b0;
        end else begin
            wb_valid_o       <= ~bubble;
            reg_write_o      <= reg_write & ~bubble;
            mem_to_reg_o     <= bubble ? '0 : mem_to_reg;
            read_data_o      <= bubble ? '0 : read_data;
            alu_result_o     <= bubble ? '0 : alu_result;
            write_register_o <= bubble ? '0 : write_register;
            align_err_o      <= align_err;
            bus_err_o        <= bus_err;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch/jump redirect, load/store over a req/ready port,
// and an IDLE/WAIT FSM that stalls upstream and times out a silent bus.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [MTR_W-1:0]      mem_to_reg_i,
    input  logic                  jump_i,
    input  logic                  branch_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic                  reg_write_i,
    input  logic [DATA_W-1:0]     pc_beq_i,
    input  logic [DATA_W-1:0]     alu_result_i,
    input  logic [DATA_W-1:0]     read_data2_i,
    input  logic                  zero_flag_i,
    input  logic [REG_ADDR_W-1:0] write_register_i,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic [DATA_W-1:0]     dmem_rdata,
    input  logic                  dmem_ready,
    output logic                  stall_o,
    output logic                  pc_src_o,
    output logic [DATA_W-1:0]     branch_target_o,
    output logic [MTR_W-1:0]      mem_to_reg_o,
    output logic                  reg_write_o,
    output logic                  wb_valid_o,
    output logic [DATA_W-1:0]     read_data_o,
    output logic [DATA_W-1:0]     alu_result_o,
    output logic [REG_ADDR_W-1:0] write_register_o,
    output logic                  align_err_o,
    output logic                  bus_err_o
);

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = (MAX_WAIT > 0) ? CNT_W'(MAX_WAIT - 1) : '0;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  access, aligned, timeout;
    logic                  req, stall, latch_en;

    logic                  lat_we, lat_reg_write;
    logic [MTR_W-1:0]      lat_mem_to_reg;
    logic [DATA_W-1:0]     lat_alu, lat_wdata;
    logic [REG_ADDR_W-1:0] lat_wr_reg;

    logic                  wb_bubble, wb_reg_write, wb_align_err, wb_bus_err;
    logic [MTR_W-1:0]      wb_mem_to_reg;
    logic [DATA_W-1:0]     wb_read_data, wb_alu;
    logic [REG_ADDR_W-1:0] wb_wr_reg;

    assign access  = mem_read_i | mem_write_i;
    assign aligned = (alu_result_i[1:0] == 2'b00);
    assign timeout = (MAX_WAIT != 0) && (wait_cnt == LAST_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wait_cnt <= '0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= (state_q == WAIT && state_d == WAIT) ? wait_cnt + CNT_W'(1) : '0;
        end
    end

    // Request fields held steady while the bus is slow; abandoned on reset
    always_ff @(posedge clk) begin
        if (latch_en) begin
            lat_we         <= mem_write_i;
            lat_reg_write  <= reg_write_i;
            lat_mem_to_reg <= mem_to_reg_i;
            lat_alu        <= alu_result_i;
            lat_wdata      <= read_data2_i;
            lat_wr_reg     <= write_register_i;
        end
    end

    always_comb begin
        state_d       = state_q;
        req           = 1'b0;
        stall         = 1'b0;
        latch_en      = 1'b0;
        dmem_we       = 1'b0;
        dmem_addr     = alu_result_i;
        dmem_wdata    = read_data2_i;
        wb_bubble     = 1'b0;
        wb_mem_to_reg = mem_to_reg_i;
        wb_reg_write  = reg_write_i;
        wb_read_data  = '0;
        wb_alu        = alu_result_i;
        wb_wr_reg     = write_register_i;
        wb_align_err  = 1'b0;
        wb_bus_err    = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && aligned) begin
                    req     = 1'b1;
                    dmem_we = mem_write_i;
                    if (dmem_ready) begin
                        wb_read_data = (mem_read_i && !mem_write_i) ? dmem_rdata : '0;
                    end else begin
                        stall     = 1'b1;
                        latch_en  = 1'b1;
                        wb_bubble = 1'b1;
                        state_d   = WAIT;
                    end
                end else if (access) begin
                    wb_reg_write = 1'b0;
                    wb_align_err = 1'b1;
                end
            end
            WAIT: begin
                req           = 1'b1;
                dmem_we       = lat_we;
                dmem_addr     = lat_alu;
                dmem_wdata    = lat_wdata;
                wb_mem_to_reg = lat_mem_to_reg;
                wb_reg_write  = lat_reg_write;
                wb_alu        = lat_alu;
                wb_wr_reg     = lat_wr_reg;
                if (dmem_ready) begin
                    wb_read_data = lat_we ? '0 : dmem_rdata;
                    state_d      = IDLE;
                end else if (timeout) begin
                    wb_bubble  = 1'b1;
                    wb_bus_err = 1'b1;
                    state_d    = IDLE;
                end else begin
                    stall     = 1'b1;
                    wb_bubble = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dmem_req        = req & ~reset;
    assign stall_o         = stall & ~reset;
    assign pc_src_o        = ~reset & (state_q == IDLE) & (jump_i | (branch_i & zero_flag_i));
    assign branch_target_o = pc_beq_i;

    mem_wb_reg u_mem_wb_reg (
        .clk              (clk),
        .reset            (reset),
        .bubble           (wb_bubble),
        .mem_to_reg       (wb_mem_to_reg),
        .reg_write        (wb_reg_write),
        .read_data        (wb_read_data),
        .alu_result       (wb_alu),
        .write_register   (wb_wr_reg),
        .align_err        (wb_align_err),
        .bus_err          (wb_bus_err),
        .mem_to_reg_o     (mem_to_reg_o),
        .reg_write_o      (reg_write_o),
        .wb_valid_o       (wb_valid_o),
        .read_data_o      (read_data_o),
        .alu_result_o     (alu_result_o),
        .write_register_o (write_register_o),
        .align_err_o      (align_err_o),
        .bus_err_o        (bus_err_o)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected MEM/WB contents are queued when a
// step is driven and compared one edge later; combinational outputs checked mid-cycle.
module tb_mem_stage;
    import mem_stage_pkg::*;

    typedef struct {
        logic        valid;
        logic        rw;
        logic [1:0]  mtr;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic        aerr;
        logic        berr;
    } wb_t;

    logic        clk, reset;
    logic [1:0]  mem_to_reg_i;
    logic        jump_i, branch_i, mem_read_i, mem_write_i, reg_write_i, zero_flag_i;
    logic [31:0] pc_beq_i, alu_result_i, read_data2_i, dmem_rdata;
    logic [4:0]  write_register_i;
    logic        dmem_ready;
    logic        dmem_req, dmem_we, stall_o, pc_src_o;
    logic [31:0] dmem_addr, dmem_wdata, branch_target_o, read_data_o, alu_result_o;
    logic [1:0]  mem_to_reg_o;
    logic        reg_write_o, wb_valid_o, align_err_o, bus_err_o;
    logic [4:0]  write_register_o;

    int n_assert = 0;
    int n_fail   = 0;
    wb_t exp_q[$];

    mem_stage #(.MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .mem_to_reg_i(mem_to_reg_i), .jump_i(jump_i), .branch_i(branch_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .reg_write_i(reg_write_i),
        .pc_beq_i(pc_beq_i), .alu_result_i(alu_result_i), .read_data2_i(read_data2_i),
        .zero_flag_i(zero_flag_i), .write_register_i(write_register_i),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .stall_o(stall_o), .pc_src_o(pc_src_o), .branch_target_o(branch_target_o),
        .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o), .wb_valid_o(wb_valid_o),
        .read_data_o(read_data_o), .alu_result_o(alu_result_o),
        .write_register_o(write_register_o), .align_err_o(align_err_o), .bus_err_o(bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_comb(input string tag, input logic req, input logic stall, input logic pcs);
        chk({tag, ".dmem_req"}, {31'd0, dmem_req}, {31'd0, req});
        chk({tag, ".stall_o"},  {31'd0, stall_o},  {31'd0, stall});
        chk({tag, ".pc_src_o"}, {31'd0, pc_src_o}, {31'd0, pcs});
    endtask

    task automatic chk_bus(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
        chk({tag, ".dmem_we"},    {31'd0, dmem_we}, {31'd0, we});
        chk({tag, ".dmem_addr"},  dmem_addr,  addr);
        chk({tag, ".dmem_wdata"}, dmem_wdata, wdata);
    endtask

    task automatic chk_regs(input string tag, input wb_t e);
        chk({tag, ".wb_valid"},  {31'd0, wb_valid_o},  {31'd0, e.valid});
        chk({tag, ".reg_write"}, {31'd0, reg_write_o}, {31'd0, e.rw});
        chk({tag, ".mem_to_reg"}, {30'd0, mem_to_reg_o}, {30'd0, e.mtr});
        chk({tag, ".read_data"}, read_data_o, e.rdata);
        chk({tag, ".alu_result"}, alu_result_o, e.alu);
        chk({tag, ".write_reg"}, {27'd0, write_register_o}, {27'd0, e.wr});
        chk({tag, ".align_err"}, {31'd0, align_err_o}, {31'd0, e.aerr});
        chk({tag, ".bus_err"},   {31'd0, bus_err_o},   {31'd0, e.berr});
    endtask

    function automatic wb_t mk(input logic v, input logic rw, input logic [1:0] mtr,
                               input logic [31:0] rd, input logic [31:0] alu,
                               input logic [4:0] wr, input logic ae, input logic be);
        wb_t w;
        w.valid = v; w.rw = rw; w.mtr = mtr; w.rdata = rd;
        w.alu = alu; w.wr = wr; w.aerr = ae; w.berr = be;
        return w;
    endfunction

    function automatic wb_t bubble(input logic be);
        return mk(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 1'b0, be);
    endfunction

    // Advance one edge and compare the MEM/WB bank with the oldest expectation
    task automatic tick(input string tag);
        wb_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk_regs(tag, e);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] mtr,
                         input logic rw, input logic [4:0] wreg);
        mem_read_i = rd; mem_write_i = wr; alu_result_i = addr;
        read_data2_i = wdata; mem_to_reg_i = mtr; reg_write_i = rw;
        write_register_i = wreg;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        jump_i = 1'b1; branch_i = 1'b0; zero_flag_i = 1'b0; pc_beq_i = 32'h0;
        dmem_ready = 1'b0; dmem_rdata = 32'h0;
        drive(1'b1, 1'b0, 32'h100, 32'h0, MTR_MEM, 1'b1, 5'd1);

        // Reset state: request, stall and redirect gated, MEM/WB cleared
        repeat (2) @(posedge clk);
        #2;
        chk_comb("reset", 1'b0, 1'b0, 1'b0);
        chk_regs("reset", bubble(1'b0));
        reset = 1'b0;
        jump_i = 1'b0;

        // Zero-wait load
        dmem_ready = 1'b1; dmem_rdata = 32'h12345678;
        drive(1'b1, 1'b0, 32'h100, 32'h0, MTR_MEM, 1'b1, 5'd7);
        chk_comb("load0", 1'b1, 1'b0, 1'b0);
        chk_bus("load0", 1'b0, 32'h100, 32'h0);
        exp_q.push_back(mk(1'b1, 1'b1, MTR_MEM, 32'h12345678, 32'h100, 5'd7, 1'b0, 1'b0));
        tick("load0.wb");

        // Store with three stall cycles; inputs scrambled to prove latching
        dmem_ready = 1'b0; dmem_rdata = 32'h55555555;
        drive(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, MTR_ALU, 1'b0, 5'd4);
        chk_comb("st.idle", 1'b1, 1'b1, 1'b0);
        chk_bus("st.idle", 1'b1, 32'h20, 32'hDEADBEEF);
        exp_q.push_back(bubble(1'b0));
        tick("st.idle.wb");
        jump_i = 1'b1;
        drive(1'b1, 1'b0, 32'hFFF0, 32'h0, MTR_PC4, 1'b1, 5'd30);
        for (int i = 0; i < 2; i++) begin
            chk_comb("st.wait", 1'b1, 1'b1, 1'b0);
            chk_bus("st.wait", 1'b1, 32'h20, 32'hDEADBEEF);
            exp_q.push_back(bubble(1'b0));
            tick("st.wait.wb");
        end
        dmem_ready = 1'b1;
        #1;
        chk_comb("st.done", 1'b1, 1'b0, 1'b0);
        chk_bus("st.done", 1'b1, 32'h20, 32'hDEADBEEF);
        exp_q.push_back(mk(1'b1, 1'b0, MTR_ALU, 32'h0, 32'h20, 5'd4, 1'b0, 1'b0));
        tick("st.done.wb");

        // Branch / jump redirect in IDLE with no access
        jump_i = 1'b0; branch_i = 1'b1; zero_flag_i = 1'b1; pc_beq_i = 32'h40;
        drive(1'b0, 1'b0, 32'h55, 32'h0, MTR_PC4, 1'b1, 5'd3);
        chk_comb("beq.taken", 1'b0, 1'b0, 1'b1);
        chk("beq.target", branch_target_o, 32'h40);
        exp_q.push_back(mk(1'b1, 1'b1, MTR_PC4, 32'h0, 32'h55, 5'd3, 1'b0, 1'b0));
        tick("beq.taken.wb");
        zero_flag_i = 1'b0;
        #1;
        chk_comb("beq.not", 1'b0, 1'b0, 1'b0);
        exp_q.push_back(mk(1'b1, 1'b1, MTR_PC4, 32'h0, 32'h55, 5'd3, 1'b0, 1'b0));
        tick("beq.not.wb");
        branch_i = 1'b0; jump_i = 1'b1; pc_beq_i = 32'h80;
        #1;
        chk_comb("jump", 1'b0, 1'b0, 1'b1);
        chk("jump.target", branch_target_o, 32'h80);
        exp_q.push_back(mk(1'b1, 1'b1, MTR_PC4, 32'h0, 32'h55, 5'd3, 1'b0, 1'b0));
        tick("jump.wb");
        jump_i = 1'b0;

        // Misaligned load: no request, one-cycle align error, no writeback
        drive(1'b1, 1'b0, 32'h102, 32'h0, MTR_MEM, 1'b1, 5'd9);
        chk_comb("misalign", 1'b0, 1'b0, 1'b0);
        exp_q.push_back(mk(1'b1, 1'b0, MTR_MEM, 32'h0, 32'h102, 5'd9, 1'b1, 1'b0));
        tick("misalign.wb");
        drive(1'b0, 1'b0, 32'h8, 32'h0, MTR_ALU, 1'b1, 5'd2);
        exp_q.push_back(mk(1'b1, 1'b1, MTR_ALU, 32'h0, 32'h8, 5'd2, 1'b0, 1'b0));
        tick("misalign.after");

        // Bus timeout with MAX_WAIT=4: four stall cycles then a bus error bubble
        dmem_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h200, 32'h0, MTR_MEM, 1'b1, 5'd11);
        for (int i = 0; i < 4; i++) begin
            chk_comb("tmo.stall", 1'b1, 1'b1, 1'b0);
            exp_q.push_back(bubble(1'b0));
            tick("tmo.stall.wb");
        end
        chk_comb("tmo.last", 1'b1, 1'b0, 1'b0);
        chk("tmo.addr", dmem_addr, 32'h200);
        exp_q.push_back(bubble(1'b1));
        tick("tmo.berr.wb");
        drive(1'b0, 1'b0, 32'hC, 32'h0, MTR_ALU, 1'b1, 5'd12);
        chk_comb("tmo.idle", 1'b0, 1'b0, 1'b0);
        exp_q.push_back(mk(1'b1, 1'b1, MTR_ALU, 32'h0, 32'hC, 5'd12, 1'b0, 1'b0));
        tick("tmo.after");

        // Reset asserted mid-WAIT abandons the access
        drive(1'b1, 1'b0, 32'h300, 32'h0, MTR_MEM, 1'b1, 5'd13);
        exp_q.push_back(bubble(1'b0));
        tick("rst.idle.wb");
        chk_comb("rst.wait", 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        chk_comb("rst.async", 1'b0, 1'b0, 1'b0);
        chk_regs("rst.async", bubble(1'b0));
        @(posedge clk);
        #2;
        chk_regs("rst.held", bubble(1'b0));
        reset = 1'b0;
        dmem_ready = 1'b1; dmem_rdata = 32'hCAFEF00D;
        drive(1'b1, 1'b0, 32'h400, 32'h0, MTR_MEM, 1'b1, 5'd14);
        chk_comb("rst.first", 1'b1, 1'b0, 1'b0);
        chk_bus("rst.first", 1'b0, 32'h400, 32'h0);
        exp_q.push_back(mk(1'b1, 1'b1, MTR_MEM, 32'hCAFEF00D, 32'h400, 5'd14, 1'b0, 1'b0));
        tick("rst.first.wb");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage; sits directly downstream of the EX/MEM pipeline register and drives the MEM/WB outputs.
- Resolves branch/jump redirect and performs load/store through a req/ready data-memory port.
- A 2-state FSM absorbs multi-cycle memory latency and raises a pipeline stall; a wait counter enforces a bus timeout.

Parameters:
- MAX_WAIT, 16, maximum WAIT cycles before bus timeout; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-high; clock clk
- mem_to_reg_i  in  2  writeback select from EX/MEM
- jump_i, branch_i, mem_read_i, mem_write_i, reg_write_i  in  1 each  control from EX/MEM
- pc_beq_i  in  32  branch/jump target
- alu_result_i  in  32  ALU result / memory address
- read_data2_i  in  32  store data
- zero_flag_i  in  1  ALU zero
- write_register_i  in  5  destination register
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address
- dmem_wdata  out  32  store data
- dmem_rdata  in  32  load data, valid when dmem_ready=1
- dmem_ready  in  1  access completes this cycle
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- pc_src_o  out  1  take redirect
- branch_target_o  out  32  redirect PC
- mem_to_reg_o  out  2  registered, MEM/WB
- reg_write_o  out  1  registered, MEM/WB
- wb_valid_o  out  1  registered; 0 = bubble
- read_data_o  out  32  registered load data
- alu_result_o  out  32  registered
- write_register_o  out  5  registered
- align_err_o  out  1  registered 1-cycle pulse, misaligned access
- bus_err_o  out  1  registered 1-cycle pulse, timeout

Behaviour:
- Reset clears all registered outputs to 0 and forces state IDLE and wait count 0.
- While reset=1: dmem_req=0, stall_o=0, pc_src_o=0.
- Reset during WAIT abandons the access; no writeback follows.
- Access: mem_read_i | mem_write_i.
  - mem_write_i has priority if both are set.
  - aligned = alu_result_i[1:0]==0.
- IDLE, aligned access:
  - Combinational outputs: dmem_req=1, dmem_we=mem_write_i, dmem_addr=alu_result_i, dmem_wdata=read_data2_i.
  - dmem_ready=1 same cycle (zero-wait): no stall; at next edge MEM/WB regs load the inputs, read_data_o = mem_read ? dmem_rdata : 0, wb_valid_o=1.
  - dmem_ready=0: latch addr, wdata, we, mem_to_reg, reg_write, write_register, alu_result; go WAIT; stall_o=1 this cycle; at next edge load a bubble (wb_valid_o=0, reg_write_o=0).
- IDLE, misaligned access:
  - No request issued.
  - Next edge: align_err_o=1, wb_valid_o=1, reg_write_o=0, other fields passed through.
- IDLE, no access: next edge passes inputs through with read_data_o=0 and wb_valid_o=1.
- pc_src_o = IDLE & (jump_i | (branch_i & zero_flag_i)), combinational.
  - branch_target_o = pc_beq_i, always.
  - pc_src_o=0 in WAIT.
- WAIT:
  - dmem_req=1 with latched fields.
  - stall_o = ~dmem_ready.
  - Wait counter increments each cycle.
  - dmem_ready=1: next edge loads latched fields plus rdata (loads), wb_valid_o=1; go IDLE; counter cleared.
  - No ready and counter == MAX_WAIT-1 (MAX_WAIT≠0): go IDLE, bus_err_o=1, bubble written, stall released the same cycle.
  - Ready and timeout in the same cycle: ready wins.
- Inputs are ignored in WAIT; upstream is frozen by stall_o.
- After completion, a new access may issue in the very next IDLE cycle; back-to-back accesses are legal.
- align_err_o and bus_err_o return to 0 on the following edge.

Decomposition:
- Shared pipeline package holds:
  - MemtoReg encodings (00 ALU, 01 MEM, 10 PC+4).
  - FSM state enum {IDLE, WAIT}.
  - Data-path width constants.
- One natural sub-module: mem_wb_reg, the registered MEM/WB output bank with bubble insert. FSM and counter stay in mem_stage.

Test Plan:
- Load, addr 0x100, dmem_ready held 1 -> dmem_req same cycle, stall_o=0; next edge read_data_o=dmem_rdata, wb_valid_o=1, reg_write_o=1.
- Store, addr 0x20, wdata 0xDEADBEEF, ready after 3 cycles -> stall_o=1 for 3 cycles, dmem_we=1 and addr/wdata stable throughout; then IDLE, reg_write_o=0.
- Branch with zero_flag_i=1, pc_beq_i=0x40 -> pc_src_o=1, branch_target_o=0x40; zero_flag_i=0 -> pc_src_o=0; jump_i=1 -> pc_src_o=1.
- Load at 0x102 -> no dmem_req, align_err_o pulses 1 cycle, reg_write_o=0.
- MAX_WAIT=4, ready never -> stall for 4 cycles, bus_err_o pulse, bubble written, FSM IDLE.
- Reset asserted mid-WAIT -> dmem_req and stall_o drop immediately, all outputs 0; the first access after release issues normally.
